// File: rtl/maxpool_window_buffer_if.sv
// Handshake bundle for the 2x2 max-pool window gatherer:
// pixel stream in, four-word window out.
interface maxpool_window_buffer_if;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             win_valid;
  logic             win_ready;
  logic [3:0][31:0] win;
  logic             frame_done;

  modport master (
    output in_valid,
    output in_data,
    output win_ready,
    input  in_ready,
    input  win_valid,
    input  win,
    input  frame_done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  win_ready,
    output in_ready,
    output win_valid,
    output win,
    output frame_done
  );
endinterface

// File: rtl/maxpool_window_buffer.sv
// Streaming 2x2 window gatherer ahead of the max-pool stage.
// Optional: define MAXPOOL_RELU_EN to zero negative pixels on entry.
module maxpool_window_buffer #(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28
) (
  input logic clk,
  input logic reset,
  maxpool_window_buffer_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [31:0]   line_buf [WIDTH];
  logic [31:0]   held;
  logic [31:0]   pix;
  logic          acc;
  logic          col_last;
  logic          row_last;

  assign bus.in_ready = !bus.win_valid || bus.win_ready;
  assign acc          = bus.in_valid && bus.in_ready;
  assign col_last     = col == CW'(WIDTH - 1);
  assign row_last     = row == RW'(HEIGHT - 1);

  always_comb begin
`ifdef MAXPOOL_RELU_EN
    pix = bus.in_data[31] ? 32'h0 : bus.in_data;
`else
    pix = bus.in_data;
`endif
  end

  // Contents are don't-care after reset; every entry is rewritten
  // on the even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (acc && !row[0])
      line_buf[col] <= pix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col            <= '0;
      row            <= '0;
      held           <= '0;
      bus.win_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.win        <= '0;
    end else begin
      if (bus.win_valid && bus.win_ready)
        bus.win_valid <= 1'b0;
      if (acc) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (row[0]) begin
          if (!col[0]) begin
            held <= pix;
          end else begin
            bus.win[0]     <= line_buf[col - CW'(1)];
            bus.win[1]     <= line_buf[col];
            bus.win[2]     <= held;
            bus.win[3]     <= pix;
            bus.win_valid  <= 1'b1;
            bus.frame_done <= row_last && col_last;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_maxpool_window_buffer.sv
// Self-checking bench for maxpool_window_buffer: three geometries
// (4x2, 4x4, 28x28) against a window-list reference model.
module tb_maxpool_window_buffer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int sel;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             win_ready;
  logic             in_ready;
  logic             win_valid;
  logic [3:0][31:0] win;
  logic             frame_done;

  int checks = 0;
  int errors = 0;

  maxpool_window_buffer_if ia ();
  maxpool_window_buffer_if ib ();
  maxpool_window_buffer_if ic ();

  assign ia.in_valid  = in_valid && sel == 0;
  assign ib.in_valid  = in_valid && sel == 1;
  assign ic.in_valid  = in_valid && sel == 2;
  assign ia.win_ready = win_ready && sel == 0;
  assign ib.win_ready = win_ready && sel == 1;
  assign ic.win_ready = win_ready && sel == 2;
  assign ia.in_data   = in_data;
  assign ib.in_data   = in_data;
  assign ic.in_data   = in_data;

  always_comb begin
    in_ready   = ia.in_ready;
    win_valid  = ia.win_valid;
    win        = ia.win;
    frame_done = ia.frame_done;
    if (sel == 1) begin
      in_ready   = ib.in_ready;
      win_valid  = ib.win_valid;
      win        = ib.win;
      frame_done = ib.frame_done;
    end else if (sel == 2) begin
      in_ready   = ic.in_ready;
      win_valid  = ic.win_valid;
      win        = ic.win;
      frame_done = ic.frame_done;
    end
  end

  maxpool_window_buffer #(.WIDTH(4), .HEIGHT(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ia.slave));
  maxpool_window_buffer #(.WIDTH(4), .HEIGHT(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave));
  maxpool_window_buffer #(.WIDTH(28), .HEIGHT(28)) dut_c (
    .clk(clk), .reset(reset), .bus(ic.slave));

  typedef struct {
    logic [3:0][31:0] w;
    logic             fd;
  } win_t;

  logic [31:0] pix_q [$];
  win_t        exp_q [$];
  logic [31:0] fl [16];

  function automatic logic [31:0] relu(input logic [31:0] p);
`ifdef MAXPOOL_RELU_EN
    return p[31] ? 32'h0 : p;
`else
    return p;
`endif
  endfunction

  task automatic cyc_drive(input logic v, input logic [31:0] d,
                           input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    win_ready = r;
    @(negedge clk);
  endtask

  // Streams pix_q (nf frames of w x h) and checks every window.
  task automatic stream(input int w, input int h, input int nf,
                        input bit rin, input bit rout);
    int n, sent, got, nwin, budget, p, r, c, b;
    bit vis, hold;
    logic [3:0][31:0] pw;
    win_t e;
    exp_q.delete();
    for (int f = 0; f < nf; f++)
      for (int rr = 0; rr < h; rr += 2)
        for (int cc = 0; cc < w; cc += 2) begin
          b = f * w * h;
          e.w[0] = relu(pix_q[b + rr * w + cc]);
          e.w[1] = relu(pix_q[b + rr * w + cc + 1]);
          e.w[2] = relu(pix_q[b + (rr + 1) * w + cc]);
          e.w[3] = relu(pix_q[b + (rr + 1) * w + cc + 1]);
          e.fd   = (rr == h - 2) && (cc == w - 2);
          exp_q.push_back(e);
        end
    n = pix_q.size();
    nwin = exp_q.size();
    sent = 0;
    got = 0;
    vis = 0;
    hold = 0;
    pw = '0;
    budget = 20 * n + 100;
    for (int cyc = 0; cyc < budget && got < nwin; cyc++) begin
      @(posedge clk);
      #1;
      in_valid  = sent < n && (!rin || $urandom_range(0, 3) != 0);
      in_data   = sent < n ? pix_q[sent] : 32'h0;
      win_ready = !rout || $urandom_range(0, 2) != 0;
      @(negedge clk);
      if (vis) begin
        checks++;
        if (win_valid !== 1'b1) begin
          errors++;
          $display("FAIL latency: win_valid=%b required 1 (win %0d)",
                   win_valid, got);
        end
      end
      if (hold) begin
        checks++;
        if (win !== pw) begin
          errors++;
          $display("FAIL hold: win=%h required %h", win, pw);
        end
      end
      if (win_valid && win_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_window: win=%h required none", win);
        end else begin
          e = exp_q.pop_front();
          if (win !== e.w || frame_done !== e.fd) begin
            errors++;
            $display("FAIL window %0d: win=%h fd=%b required %h fd=%b",
                     got, win, frame_done, e.w, e.fd);
          end
        end
        got++;
      end
      vis = 0;
      if (in_valid && in_ready) begin
        p = sent % (w * h);
        r = p / w;
        c = p % w;
        vis = (r % 2 == 1) && (c % 2 == 1);
        sent++;
      end
      hold = win_valid && !win_ready;
      pw = win;
    end
    in_valid = 0;
    checks++;
    if (got != nwin || exp_q.size() != 0 || sent != n) begin
      errors++;
      $display("FAIL count: windows=%0d sent=%0d required %0d and %0d",
               got, sent, nwin, n);
    end
    win_ready = 1;
    cyc_drive(0, 32'h0, 1);
    checks++;
    if (win_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle: win_valid=%b required 0", win_valid);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1;
    in_valid = 0;
    win_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (in_ready !== 1'b1 || win_valid !== 1'b0 ||
          frame_done !== 1'b0 || win !== '0) begin
        errors++;
        $display("FAIL reset dut%0d: rdy=%b v=%b fd=%b win=%h required 1 0 0 0",
                 s, in_ready, win_valid, frame_done, win);
      end
    end
  endtask

  task automatic test_basic();
    sel = 0;
    pix_q.delete();
    for (int i = 0; i < 8; i++) pix_q.push_back(fl[i]);
    stream(4, 2, 1, 0, 0);
  endtask

  task automatic test_stall();
    logic [3:0][31:0] w1, w2;
    sel = 0;
    w1 = {fl[5], fl[4], fl[1], fl[0]};
    w2 = {fl[7], fl[6], fl[3], fl[2]};
    for (int i = 0; i < 6; i++) cyc_drive(1, fl[i], 1);
    for (int k = 0; k < 4; k++) begin
      cyc_drive(1, fl[6], 0);
      checks++;
      if (in_ready !== 1'b0 || win_valid !== 1'b1 || win !== w1) begin
        errors++;
        $display("FAIL stall %0d: rdy=%b v=%b win=%h required 0 1 %h",
                 k, in_ready, win_valid, win, w1);
      end
    end
    cyc_drive(1, fl[6], 1);
    checks++;
    if (in_ready !== 1'b1 || win_valid !== 1'b1) begin
      errors++;
      $display("FAIL release: rdy=%b v=%b required 1 1",
               in_ready, win_valid);
    end
    cyc_drive(1, fl[7], 1);
    checks++;
    if (win_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain: v=%b rdy=%b required 0 1",
               win_valid, in_ready);
    end
    cyc_drive(0, 32'h0, 1);
    checks++;
    if (win_valid !== 1'b1 || win !== w2 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL second: v=%b win=%h fd=%b required 1 %h 1",
               win_valid, win, frame_done, w2);
    end
    cyc_drive(0, 32'h0, 1);
    checks++;
    if (win_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_second: v=%b required 0", win_valid);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1;
    pix_q.delete();
    for (int i = 0; i < 32; i++) pix_q.push_back($urandom);
    stream(4, 4, 2, 0, 0);
  endtask

  task automatic test_reset_mid();
    sel = 0;
    for (int i = 0; i < 5; i++) cyc_drive(1, fl[i], 1);
    do_reset();
    #1;
    checks++;
    if (win_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: v=%b rdy=%b required 0 1",
               win_valid, in_ready);
    end
    pix_q.delete();
    for (int i = 8; i < 16; i++) pix_q.push_back(fl[i]);
    stream(4, 2, 1, 0, 0);
  endtask

  task automatic test_relu();
    sel = 0;
    pix_q.delete();
    for (int i = 0; i < 7; i++) pix_q.push_back(fl[i]);
    pix_q.push_back(32'hC000_0000);
    stream(4, 2, 1, 0, 0);
    pix_q.delete();
    for (int i = 0; i < 16; i++) pix_q.push_back($urandom);
    stream(4, 2, 2, 1, 1);
  endtask

  task automatic test_random();
    sel = 2;
    pix_q.delete();
    for (int i = 0; i < 28 * 28; i++) pix_q.push_back($urandom);
    stream(28, 28, 1, 1, 1);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $shortrealtobits(shortreal'(i + 1));
      fl[i] = v;
    end
    sel = 0;
    reset = 1;
    in_valid = 0;
    in_data = 0;
    win_ready = 0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_relu();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/maxpool_window_buffer.md
# maxpool_window_buffer

Streaming 2x2 window gatherer directly upstream of the 2x2 max-pool stage. Accepts one 32-bit IEEE-754 single-precision pixel per handshake in row-major order, buffers one even row, and emits each non-overlapping 2x2 window as four words on the pool's four-word input bus. Sits between the convolution output stream and the max-pool comparator tree. Produces one window per two input pixels on odd rows.

## Interface
- WIDTH, 28, feature-map width in pixels; must be even, at least 2
- HEIGHT, 28, feature-map height in pixels; must be even, at least 2
- Clk  input  1  single clock, all logic on rising edge
- Reset  input  1  synchronous, active-high; clears counters and output register
- in_valid  input  1  in_data holds a valid pixel
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  32  float32 pixel
- win_valid  output  1  win holds a complete window
- win_ready  input  1  downstream accepts win this cycle
- win  output  32 x [3:0]  window: [0] top-left, [1] top-right, [2] bottom-left, [3] bottom-right
- frame_done  output  1  high with the last window of a frame (valid only while win_valid)

## Operation
- Transfer on input when in_valid && in_ready; on output when win_valid && win_ready.
- Counters: col 0..WIDTH-1, row 0..HEIGHT-1, advance once per input transfer. col wraps to 0 and row increments at col==WIDTH-1; both wrap to 0 after (WIDTH-1, HEIGHT-1).
- Even row: pixel written to line buffer entry col (WIDTH x 32 registers or RAM). No window produced.
- Odd row, even col: pixel stored in held register (bottom-left).
- Odd row, odd col: output register loads win[0]=line[col-1], win[1]=line[col], win[2]=held, win[3]=in_data (after Configuration transform); win_valid set. frame_done set when row==HEIGHT-1 and col==WIDTH-1, else cleared.
- in_ready = !win_valid || win_ready (single-entry output skid; combinational from win_ready). in_ready ignores row/col; even-row pixels are never stalled except through that expression.
- Output register holds win and frame_done stable while win_valid && !win_ready.
- Simultaneous output drain and new window load in the same cycle: new window loaded, win_valid stays 1.
- Drain with no new window: win_valid cleared next cycle.
- Line buffer entries for the current window are read before being overwritten; the next even row overwrites only after all windows of the previous pair are formed, which the row ordering guarantees.
- No arithmetic on data; words pass bit-exact except the optional transform.

## Timing
- Reset values: in_ready 1 (derived), win_valid 0, frame_done 0, win all zeros, col 0, row 0, held 0. Line buffer contents are don't-care after reset.
- Reset mid-frame: partial frame discarded, any pending window dropped; the next accepted pixel is (row 0, col 0).
- Latency: window visible (win_valid high) the cycle after the bottom-right pixel transfer.
- Throughput: one pixel per cycle sustained when win_ready stays high; one window every 2 cycles on odd rows.
- in_valid high with in_ready low: pixel not consumed; counters unchanged.

## Configuration
- MAXPOOL_RELU_EN defined: every accepted pixel with bit 31 set is replaced by 32'h0000_0000 before storage or output (ReLU fused ahead of pooling); non-negative pixels unchanged.
- Undefined: pixels stored and output bit-exact, sign preserved.

## Test plan
- WIDTH=4, HEIGHT=2, pixels 1.0..8.0 (32'h3F800000 …) streamed, win_ready=1 -> two windows {1,2,5,6} then {3,4,7,8}; frame_done high only with the second; win_valid one cycle after pixels 6 and 8.
- Same frame, win_ready held 0 after first window -> in_ready drops the cycle after pixel 6 accepted; win stable; after win_ready=1, pixel 7 accepted same cycle, second window correct.
- Two back-to-back 4x4 frames, continuous valid -> 8 windows, frame_done on 4th and 8th, second frame windows use only second-frame data.
- Reset asserted after pixel 5 of a 4x2 frame, then full frame 9..16 -> no window from old data; windows {9,10,13,14}, {11,12,15,16}.
- Pixel -2.0 (32'hC0000000) at bottom-right: with MAXPOOL_RELU_EN win[3]=32'h00000000; without, win[3]=32'hC0000000.
- Random in_valid/win_ready gaps over a 28x28 frame vs. scoreboard -> 196 windows, exact match, no drop or duplicate.
